bios_failover_ctrl: RTL and testbench
=====================================

// Module: bios_failover_ctrl
// PURPOSE
//  Boot watchdog and failover controller for the dual BIOS sockets.
//  - Decides which socket boots (Active_Bios) and which socket is armed for the next host reset (Next_Bios).
//  - These outputs feed the BIOS chip-select decode and the Next-BIOS latch.
//  - Times POST against a watchdog. On repeated boot failure it flips to the other socket and requests a host reset.
// PARAMETERS
//  WDT_WIDTH    16      width of the boot watchdog counter
//  WDT_TIMEOUT  60000   TickEn pulses allowed from host reset release to BootDone (must be >=1)
//  MAX_RETRY    2       failed boots of one socket before swapping (1..3)
// PORTS
//  Clk          in   1  system clock; all inputs are synchronous to Clk
//  ResetN       in   1  asynchronous active-low reset
//  TickEn       in   1  one-cycle timebase strobe (1 ms)
//  Pwr_ok       in   1  main power good; low = host powered off
//  PciRstN      in   1  host PCI reset, active-low; a rising edge starts a boot attempt
//  BootDone     in   1  level; high = BIOS reports POST complete
//  WdtDisable   in   1  high = watchdog frozen, no timeout
//  SelWrEn      in   1  one-cycle write strobe from the BMC/LPC register
//  SelWrData    in   1  requested next socket (0/1)
//  Active_Bios  out  1  socket currently selected (0/1)
//  Next_Bios    out  1  socket to select at the next PciRstN rise
//  BootFail     out  2  sticky per-socket failure flags; bit n = socket n exhausted retries
//  RetryCnt     out  2  failed attempts on the current socket
//  ForceRst     out  1  one-cycle pulse requesting a host reset
//  FsmState     out  3  encoded state for debug
// BEHAVIOUR
//  Reset (ResetN low)
//  - Active_Bios=0, Next_Bios=0, BootFail=00, RetryCnt=0, ForceRst=0.
//  - Watchdog count=0, FsmState=OFF.
//  States: OFF=0, HOLD=1, BOOTING=2, DONE=3, FAIL=4, HALT=5. Pwr_ok low forces OFF from any state, with priority over everything else.
//  OFF
//  - Holds Active_Bios=0, Next_Bios=0, RetryCnt=0 and the watchdog count at 0. BootFail is retained.
//  - Pwr_ok high -> HOLD.
//  HOLD (host held in reset)
//  - Cycle after PciRstN is sampled 0 then 1: Active_Bios<=Next_Bios, watchdog count<=0, next state BOOTING.
//  BOOTING
//  - Count increments on TickEn unless WdtDisable; it saturates and never wraps.
//  - BootDone=1 -> DONE. BootDone wins over a timeout in the same cycle.
//  - TickEn with count==WDT_TIMEOUT-1 and WdtDisable=0 -> FAIL.
//  - PciRstN low (external reset) -> HOLD. RetryCnt is unchanged and the count clears.
//  DONE
//  - RetryCnt<=0 and BootFail[Active_Bios]<=0. Watchdog is idle.
//  - PciRstN low -> HOLD, so a re-boot is watched again.
//  FAIL (exactly one cycle)
//  - If RetryCnt+1 < MAX_RETRY: RetryCnt++.
//  - Else: BootFail[Active_Bios]<=1, RetryCnt<=0, Next_Bios<=~Active_Bios.
//  - If BootFail will be 11 after this cycle: no ForceRst, next state HALT.
//  - Otherwise: ForceRst=1 for this cycle, next state HOLD.
//  HALT
//  - Watchdog stopped, ForceRst never pulses, outputs hold.
//  - Exits only via Pwr_ok low or ResetN.
//  SelWrEn
//  - Next_Bios<=SelWrData in any state except OFF. Takes effect at the next PciRstN rise.
//  - Loses to a FAIL-cycle swap in the same cycle.
//  - Never changes Active_Bios directly.
//  - Does not clear RetryCnt or BootFail.
//  All outputs are registered; ForceRst is high for exactly one Clk cycle.
// TESTING
//  (TB params WDT_TIMEOUT=4, MAX_RETRY=2)
//  - Power up, PciRstN 0->1, BootDone after 2 ticks -> Active_Bios=0, DONE, ForceRst never high.
//  - No BootDone, 4 ticks -> ForceRst pulse, RetryCnt=1. Second timeout -> BootFail=01, Next_Bios=1. Next PciRstN rise -> Active_Bios=1.
//  - Socket 1 also times out twice -> BootFail=11, HALT. Further ticks and PciRstN toggles cause no ForceRst.
//  - SelWrEn=1, SelWrData=1 while BOOTING -> Active_Bios stays 0 until the next PciRstN rise, then becomes 1.
//  - BootDone rises in the same cycle as the 4th tick -> DONE, RetryCnt=0, no ForceRst.
//  - Pwr_ok drops mid-BOOTING -> OFF, Active_Bios=0, Next_Bios=0. ResetN low mid-FAIL -> all reset values.

Source files
------------

// File: rtl/bios_failover_ctrl.sv
// Boot watchdog and dual-socket BIOS failover controller.
// Times POST, retries a failing socket, then swaps sockets or halts.
module bios_failover_ctrl #(
    parameter int WDT_WIDTH   = 16,
    parameter int WDT_TIMEOUT = 60000,
    parameter int MAX_RETRY   = 2
) (
    input  logic       Clk,
    input  logic       ResetN,
    input  logic       TickEn,
    input  logic       Pwr_ok,
    input  logic       PciRstN,
    input  logic       BootDone,
    input  logic       WdtDisable,
    input  logic       SelWrEn,
    input  logic       SelWrData,
    output logic       Active_Bios,
    output logic       Next_Bios,
    output logic [1:0] BootFail,
    output logic [1:0] RetryCnt,
    output logic       ForceRst,
    output logic [2:0] FsmState
);

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_HOLD = 3'd1,
        ST_BOOT = 3'd2,
        ST_DONE = 3'd3,
        ST_FAIL = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [WDT_WIDTH-1:0] WDT_LAST = WDT_WIDTH'(WDT_TIMEOUT - 1);
    localparam logic [WDT_WIDTH-1:0] WDT_MAX  = '1;

    state_t               state_q, state_d;
    logic                 active_q, active_d;
    logic                 next_q, next_d;
    logic [1:0]           fail_q, fail_d;
    logic [1:0]           retry_q, retry_d;
    logic [WDT_WIDTH-1:0] wdt_q, wdt_d;
    logic                 force_q, force_d;
    logic                 pci_q;

    logic       pci_rise;
    logic       wdt_tick;
    logic       wdt_expire;
    logic [2:0] retry_inc;
    logic       retry_exhaust;
    logic [1:0] fail_set;
    logic       will_halt;

    assign pci_rise      = PciRstN & ~pci_q;
    assign wdt_tick      = TickEn & ~WdtDisable;
    assign wdt_expire    = wdt_tick && (wdt_q == WDT_LAST);
    assign retry_inc     = {1'b0, retry_q} + 3'd1;
    assign retry_exhaust = retry_inc >= 3'(MAX_RETRY);
    assign fail_set      = fail_q | (active_q ? 2'b10 : 2'b01);
    // Retry and fail flags are stable from the timeout cycle through FAIL,
    // so the halt decision can be made one cycle early for ForceRst.
    assign will_halt     = retry_exhaust && (fail_set == 2'b11);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!Pwr_ok) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF:  state_d = ST_HOLD;
                ST_HOLD: if (pci_rise) state_d = ST_BOOT;
                ST_BOOT: begin
                    if (BootDone)        state_d = ST_DONE;
                    else if (wdt_expire) state_d = ST_FAIL;
                    else if (!PciRstN)   state_d = ST_HOLD;
                end
                ST_DONE: if (!PciRstN) state_d = ST_HOLD;
                ST_FAIL: state_d = will_halt ? ST_HALT : ST_HOLD;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_comb begin
        active_d = active_q;
        next_d   = next_q;
        fail_d   = fail_q;
        retry_d  = retry_q;
        wdt_d    = '0;
        force_d  = 1'b0;
        if (!Pwr_ok || state_q == ST_OFF) begin
            active_d = 1'b0;
            next_d   = 1'b0;
            retry_d  = 2'd0;
        end else begin
            if (SelWrEn) next_d = SelWrData;
            unique case (state_q)
                ST_HOLD: if (pci_rise) active_d = next_q;
                ST_BOOT: begin
                    if (!BootDone && !wdt_expire && PciRstN) begin
                        if (wdt_tick && wdt_q != WDT_MAX) wdt_d = wdt_q + 1'b1;
                        else                              wdt_d = wdt_q;
                    end
                    force_d = !BootDone && wdt_expire && !will_halt;
                end
                ST_DONE: begin
                    retry_d          = 2'd0;
                    fail_d[active_q] = 1'b0;
                end
                ST_FAIL: begin
                    if (!retry_exhaust) begin
                        retry_d = retry_q + 2'd1;
                    end else begin
                        fail_d  = fail_set;
                        retry_d = 2'd0;
                        next_d  = ~active_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            active_q <= 1'b0;
            next_q   <= 1'b0;
            fail_q   <= 2'b00;
            retry_q  <= 2'd0;
            wdt_q    <= '0;
            force_q  <= 1'b0;
            pci_q    <= 1'b1;
        end else begin
            active_q <= active_d;
            next_q   <= next_d;
            fail_q   <= fail_d;
            retry_q  <= retry_d;
            wdt_q    <= wdt_d;
            force_q  <= force_d;
            pci_q    <= PciRstN;
        end
    end

    assign Active_Bios = active_q;
    assign Next_Bios   = next_q;
    assign BootFail    = fail_q;
    assign RetryCnt    = retry_q;
    assign ForceRst    = force_q;
    assign FsmState    = state_q;

endmodule

// File: tb/tb_bios_failover_ctrl.sv
// Scoreboard bench for bios_failover_ctrl: directed scenarios then
// random stimulus, checked against a behavioural reference model.
module tb_bios_failover_ctrl;

    localparam int T    = 4;
    localparam int MAXR = 2;

    localparam int S_OFF  = 0;
    localparam int S_HOLD = 1;
    localparam int S_BOOT = 2;
    localparam int S_DONE = 3;
    localparam int S_FAIL = 4;
    localparam int S_HALT = 5;

    typedef struct packed {
        logic       act;
        logic       nxt;
        logic [1:0] bf;
        logic [1:0] rc;
        logic       frc;
        logic [2:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, tick, pwr, pci, done, wdis, sel_en, sel_dat;
    logic       act_o, nxt_o, frc_o;
    logic [1:0] bf_o, rc_o;
    logic [2:0] st_o;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    exp_t sb[$];

    int         m_st   = 0;
    bit         m_act  = 0;
    bit         m_nxt  = 0;
    logic [1:0] m_bf   = 0;
    int         m_rc   = 0;
    int         m_wdt  = 0;
    bit         m_prev = 1;
    bit         m_frc  = 0;

    bios_failover_ctrl #(
        .WDT_WIDTH(16), .WDT_TIMEOUT(T), .MAX_RETRY(MAXR)
    ) dut (
        .Clk(clk), .ResetN(rst_n), .TickEn(tick), .Pwr_ok(pwr),
        .PciRstN(pci), .BootDone(done), .WdtDisable(wdis),
        .SelWrEn(sel_en), .SelWrData(sel_dat),
        .Active_Bios(act_o), .Next_Bios(nxt_o), .BootFail(bf_o),
        .RetryCnt(rc_o), .ForceRst(frc_o), .FsmState(st_o)
    );

    always #5 clk = ~clk;

    // Reference model: one call per clock, using inputs sampled at that edge.
    task automatic model_step();
        bit rise;
        bit nn;
        rise  = pci && !m_prev;
        m_frc = 0;
        if (!rst_n) begin
            m_st = S_OFF; m_act = 0; m_nxt = 0; m_bf = 0;
            m_rc = 0; m_wdt = 0; m_prev = 1;
        end else begin
            nn = m_nxt;
            if (!pwr) begin
                m_st = S_OFF; m_act = 0; m_nxt = 0; m_rc = 0; m_wdt = 0;
            end else begin
                if (m_st != S_OFF && sel_en) nn = sel_dat;
                case (m_st)
                    S_OFF: m_st = S_HOLD;
                    S_HOLD: if (rise) begin
                        m_act = m_nxt; m_wdt = 0; m_st = S_BOOT;
                    end
                    S_BOOT: begin
                        if (done) m_st = S_DONE;
                        else if (tick && !wdis && m_wdt == T - 1) begin
                            m_st  = S_FAIL;
                            m_frc = !((m_rc + 1 >= MAXR) &&
                                      ((m_bf | (2'b01 << m_act)) == 2'b11));
                        end else if (!pci) begin
                            m_st = S_HOLD; m_wdt = 0;
                        end else if (tick && !wdis) m_wdt++;
                    end
                    S_DONE: begin
                        m_rc = 0; m_bf[m_act] = 1'b0;
                        if (!pci) m_st = S_HOLD;
                    end
                    S_FAIL: begin
                        if (m_rc + 1 < MAXR) m_rc++;
                        else begin
                            m_bf[m_act] = 1'b1; m_rc = 0; nn = ~m_act;
                        end
                        m_st = (m_bf == 2'b11) ? S_HALT : S_HOLD;
                    end
                    default: ;
                endcase
                m_nxt = nn;
            end
            m_prev = pci;
        end
    endtask

    task automatic step();
        exp_t e;
        model_step();
        e.act = m_act; e.nxt = m_nxt; e.bf = m_bf;
        e.rc = 2'(m_rc); e.frc = m_frc; e.st = 3'(m_st);
        sb.push_back(e);
        ncyc++;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1; step();
            tick = 0; step();
        end
    endtask

    task automatic pci_pulse();
        pci = 0; step();
        pci = 1; step();
    endtask

    initial begin : monitor
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                g = {act_o, nxt_o, bf_o, rc_o, frc_o, st_o};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got act=%b nxt=%b bf=%b rc=%0d frc=%b st=%0d exp act=%b nxt=%b bf=%b rc=%0d frc=%b st=%0d",
                             $time, g.act, g.nxt, g.bf, g.rc, g.frc, g.st,
                             e.act, e.nxt, e.bf, e.rc, e.frc, e.st);
                end
            end
        end
    end

    initial begin : driver
        rst_n = 0; pwr = 0; pci = 0; tick = 0; done = 0;
        wdis = 0; sel_en = 0; sel_dat = 0;
        repeat (3) step();
        rst_n = 1; pwr = 1;
        repeat (2) step();
        // clean boot on socket 0
        pci = 1; step();
        ticks(2);
        done = 1; step(); step();
        pci = 0; step(); done = 0; step();
        pci = 1; step();
        // two timeouts on socket 0, then swap
        ticks(5);
        pci_pulse();
        ticks(5);
        pci_pulse();
        // socket 1 fails twice -> halt
        ticks(5);
        pci_pulse();
        ticks(5);
        ticks(3); pci_pulse(); ticks(2);
        // power drop, SelWrEn while booting
        pwr = 0; step(); step();
        pwr = 1; step(); step();
        pci_pulse();
        sel_en = 1; sel_dat = 1; step(); sel_en = 0;
        ticks(1);
        // power drop mid-boot
        pwr = 0; step(); pwr = 1; step(); step();
        pci_pulse();
        sel_en = 1; sel_dat = 1; step(); sel_en = 0;
        pci_pulse(); step();
        // BootDone coincides with the 4th tick
        ticks(3);
        tick = 1; done = 1; step(); tick = 0; step();
        done = 0; pci = 0; step(); pci = 1; step();
        // reset while in FAIL
        ticks(3);
        tick = 1; step(); tick = 0;
        rst_n = 0; step(); rst_n = 1; step();
        // random phase
        for (int i = 0; i < 3000; i++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            pwr     = ($urandom_range(0, 199) != 0);
            tick    = ($urandom_range(0, 2) == 0);
            pci     = ($urandom_range(0, 19) != 0);
            done    = ($urandom_range(0, 14) == 0);
            wdis    = ($urandom_range(0, 9) == 0);
            sel_en  = ($urandom_range(0, 24) == 0);
            sel_dat = 1'($urandom);
            step();
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
